mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 88 ++++++++
 tb/tb_mul_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Shift-and-add multiplier sequencer that borrows a shared external ALU for its accumulate steps.
// One multiplier bit is consumed per CALC cycle, and the sequence stops at the highest set bit.
module mul_sequencer #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] ALU_ADD_OP = 4'b0010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_own <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        mc   <= mcand;
                        mp   <= mplier;
                        busy <= 1'b1;
                        if (mplier != '0) begin
                            state   <= CALC;
                            alu_own <= 1'b1;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            product <= '0;
                        end
                    end
                end
                CALC: begin
                    if (mp[0]) acc <= alu_result;
                    mc <= mc << 1;
                    mp <= mp >> 1;
                    if ((mp >> 1) == '0) begin
                        // acc is updated on this same edge, so capture the value it is about to take
                        state   <= DONE;
                        alu_own <= 1'b0;
                        done    <= 1'b1;
                        product <= mp[0] ? alu_result : acc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    alu_own <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a  = acc;
    assign alu_b  = mc;
    assign alu_op = ALU_ADD_OP;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed corner cases plus random operands, checked against an arithmetic model.
// The external ALU is modelled as a plain adder.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        busy, done, alu_own;
    logic [31:0] product, alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    int          total = 0;
    int          passed = 0;
    logic [31:0] last_product = '0;

    mul_sequencer #(.WIDTH(32), .ALU_ADD_OP(4'b0010)) dut (
        .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product), .alu_own(alu_own),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
    );

    assign alu_result = alu_a + alu_b;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full operation; samples every cycle from the accept edge to the first IDLE cycle after done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input bit poke);
        int          n;
        logic [31:0] exp;
        exp = a * b;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        step();
        start = hold;
        for (int k = 1; k <= n + 1; k++) begin
            if (k == 1) begin
                chk("alu_a_first", alu_a, 32'd0);
                chk("alu_b_first", alu_b, a);
            end
            if (poke && n >= 2 && k == 1) begin
                start  = 1'b1;
                mcand  = $urandom;
                mplier = $urandom | 32'd1;
            end
            if (poke && n >= 2 && k == 2) begin
                start  = hold;
                mcand  = a;
                mplier = b;
            end
            chk("busy", {31'd0, busy}, 32'd1);
            chk("alu_own", {31'd0, alu_own}, (k <= n) ? 32'd1 : 32'd0);
            chk("done", {31'd0, done}, (k == n + 1) ? 32'd1 : 32'd0);
            chk("product", product, (k == n + 1) ? exp : last_product);
            step();
        end
        last_product = exp;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_product", product, exp);
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_alu_own", {31'd0, alu_own}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd2);
        chk("rst_product", product, 32'd0);

        // directed cases, the first with a start pulse during CALC that must be ignored
        run_op(32'd6, 32'd7, 1'b0, 1'b1);
        run_op(32'h12345678, 32'd0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        run_op(32'd3, 32'h80000000, 1'b0, 1'b0);

        // start held high: each op is accepted in the IDLE cycle after the previous done
        run_op(32'd11, 32'd13, 1'b1, 1'b0);
        run_op(32'd100, 32'd0, 1'b1, 1'b0);
        run_op(32'hDEADBEEF, 32'h0000F00D, 1'b1, 1'b1);
        start = 1'b0;
        step();
        chk("held_release_busy", {31'd0, busy}, 32'd0);

        // random operands, with varied multiplier bit lengths
        for (int t = 0; t < 24; t++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (t % 7 == 0) b = 32'd0;
            run_op(a, b, 1'b0, t[0]);
        end

        // reset on the second CALC cycle aborts the op
        mcand  = 32'd6;
        mplier = 32'd7;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk("abort_calc1_own", {31'd0, alu_own}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_own", {31'd0, alu_own}, 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_b", alu_b, 32'd0);
        last_product = 32'd0;
        step();
        chk("abort_no_done", {31'd0, done}, 32'd0);
        run_op(32'd5, 32'd5, 1'b0, 1'b0);

        // reset and start on the same edge: start is discarded
        reset  = 1'b1;
        start  = 1'b1;
        mcand  = 32'd9;
        mplier = 32'd9;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        chk("rst_start_product", product, 32'd0);
        step();
        chk("rst_start_busy2", {31'd0, busy}, 32'd0);
        chk("rst_start_done", {31'd0, done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
